fp_to_int_converter: RTL and testbench

- Consumes results in the team's 32-bit float format, as produced by the float adder's data_out, and converts them to signed 32-bit two's-complement integers.
- Truncates toward zero and reports status using the adder's 4-bit status encoding.
- Multi-cycle, with a one-bit-per-cycle barrel-free shifter and a valid/ready handshake.
- Sits downstream of the adder, feeding integer consumers.

---
 rtl/fp_to_int_converter.sv | 134 +++++++++++++
 tb/tb_fp_to_int_converter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_converter.sv
// Converts the adder's 32-bit float (sign MSB, 6-bit exponent, 25-bit mantissa) to a
// signed 32-bit integer, truncating toward zero with a one-bit-per-cycle shifter.
module fp_to_int_converter #(
    parameter int BIAS   = 31,
    parameter int MANT_W = 25
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] fp_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, PACK, DONE} state_t;

    localparam logic [5:0] E_ONE  = 6'(BIAS);
    localparam logic [5:0] E_NOSH = 6'(BIAS + MANT_W);
    localparam logic [5:0] E_OVF  = 6'(BIAS + 31);

    state_t state, next_state;

    logic              in_sgn;
    logic [5:0]        in_exp;
    logic [MANT_W-1:0] in_man;

    logic [31:0] dec_shreg;
    logic [4:0]  dec_cnt;
    logic        dec_left, dec_ovf, dec_uflow;

    logic [31:0] shreg;
    logic [4:0]  cnt;
    logic        left, sticky, sgn_q, ovf_q, uflow_q;

    assign in_sgn    = fp_in[31];
    assign in_exp    = fp_in[30:25];
    assign in_man    = fp_in[MANT_W-1:0];
    assign ready_out = (state == IDLE);

    // Path selection from the raw exponent; special paths load a ready-made magnitude.
    always_comb begin
        dec_shreg = '0;
        dec_cnt   = '0;
        dec_left  = 1'b0;
        dec_ovf   = 1'b0;
        dec_uflow = 1'b0;
        if (in_exp == 6'd0) begin
            dec_uflow = |in_man;
        end else if (in_exp < E_ONE) begin
            dec_uflow = 1'b1;
        end else if (in_exp >= E_OVF) begin
            // -2^31 is the only representable magnitude at or above 2^31
            if (in_sgn && in_exp == E_OVF && in_man == '0)
                dec_shreg = 32'h8000_0000;
            else
                dec_ovf = 1'b1;
        end else if (in_exp <= E_NOSH) begin
            dec_shreg = {{(31-MANT_W){1'b0}}, 1'b1, in_man};
            dec_cnt   = 5'(E_NOSH - in_exp);
        end else begin
            dec_shreg = {{(31-MANT_W){1'b0}}, 1'b1, in_man};
            dec_cnt   = 5'(in_exp - E_NOSH);
            dec_left  = 1'b1;
        end
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (valid_in) next_state = (dec_cnt != 5'd0) ? SHIFT : PACK;
            SHIFT: if (cnt == 5'd1) next_state = PACK;
            PACK:  next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            cnt        <= '0;
            left       <= 1'b0;
            sticky     <= 1'b0;
            sgn_q      <= 1'b0;
            ovf_q      <= 1'b0;
            uflow_q    <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
            valid_out  <= 1'b0;
        end else begin
            // The pulse lands as DONE hands back to IDLE, so ready and valid overlap one cycle.
            valid_out <= (state == DONE);
            case (state)
                IDLE: if (valid_in) begin
                    shreg   <= dec_shreg;
                    cnt     <= dec_cnt;
                    left    <= dec_left;
                    sticky  <= 1'b0;
                    sgn_q   <= in_sgn;
                    ovf_q   <= dec_ovf;
                    uflow_q <= dec_uflow;
                end
                SHIFT: begin
                    cnt <= cnt - 5'd1;
                    if (left) begin
                        shreg <= shreg << 1;
                    end else begin
                        shreg  <= shreg >> 1;
                        sticky <= sticky | shreg[0];
                    end
                end
                PACK: begin
                    if (ovf_q)
                        data_out <= sgn_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    else
                        data_out <= sgn_q ? (~shreg + 32'd1) : shreg;
                    if (ovf_q)        status_out <= 4'b0010;
                    else if (uflow_q) status_out <= 4'b1100;
                    else if (sticky)  status_out <= 4'b1000;
                    else              status_out <= 4'b0001;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Scoreboard bench: stimulus pushes reference results (value, status, valid cycle);
// a negedge monitor pops and compares on every valid_out pulse.
module tb_fp_to_int_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] fp_in;
    logic        ready_out, valid_out;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    typedef struct {
        logic [31:0] word;
        logic [31:0] data;
        logic [3:0]  status;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    fp_to_int_converter dut (
        .clock_100kHz(clk),
        .reset       (rst_n),
        .valid_in    (valid_in),
        .fp_in       (fp_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .status_out  (status_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // Reference: real-number semantics via 64-bit integer arithmetic and range checks.
    function automatic void model(input logic [31:0] w, output logic [31:0] d,
                                  output logic [3:0] st, output int k);
        int     e;
        longint sig, mag, val;
        bit     inexact, ovf;
        e = int'(w[30:25]) - 31;
        k = 0;
        inexact = 0;
        ovf = 0;
        val = 0;
        if (w[30:25] == 6'd0) begin
            d  = 0;
            st = (w[24:0] == 0) ? 4'b0001 : 4'b1100;
        end else if (e < 0) begin
            d  = 0;
            st = 4'b1100;
        end else begin
            sig = (longint'(1) << 25) + longint'(w[24:0]);
            if (e >= 32) begin
                ovf = 1;
            end else begin
                if (e >= 25) begin
                    mag = sig << (e - 25);
                end else begin
                    mag     = sig >> (25 - e);
                    inexact = (sig % (longint'(1) << (25 - e))) != 0;
                end
                val = w[31] ? -mag : mag;
                ovf = (val > 64'sd2147483647) || (val < -64'sd2147483648);
            end
            if (ovf) begin
                d  = w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                st = 4'b0010;
            end else begin
                d  = val[31:0];
                st = inexact ? 4'b1000 : 4'b0001;
            end
            if (e <= 30) k = (e >= 25) ? e - 25 : 25 - e;
        end
    endfunction

    task automatic send(input logic [31:0] w);
        int        t = 0;
        exp_t      x;
        int        k;
        @(negedge clk);
        valid_in = 1'b1;
        fp_in    = w;
        while (!ready_out && t < 200) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (!ready_out) begin
            fails++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
            valid_in = 1'b0;
            return;
        end
        x.word = w;
        model(w, x.data, x.status, k);
        x.due = cyc + 1 + k + 2;
        exp_q.push_back(x);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got data 0x%08h status %b expected no output",
                         data_out, status_out);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk($sformatf("data[%08h]", x.word), data_out, x.data);
                chk($sformatf("status[%08h]", x.word), 32'(status_out), 32'(x.status));
                chk($sformatf("latency[%08h]", x.word), cyc, x.due);
            end
        end
    end

    initial begin
        logic [31:0] dir[11];
        dir = '{32'h3E00_0000, 32'hC080_0000, 32'h7C00_0000, 32'hFC00_0000,
                32'hFE00_0000, 32'h3C00_0000, 32'h0000_0000, 32'h0000_0001,
                32'h7A00_0000, 32'h7A00_0001, 32'h7200_0003};
        rst_n    = 1'b0;
        valid_in = 1'b1;
        fp_in    = 32'h3E00_0000;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready_out), 1);
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_data", data_out, 0);
        chk("reset_status", 32'(status_out), 0);
        valid_in = 1'b0;
        rst_n    = 1'b1;

        foreach (dir[i]) send(dir[i]);
        drain();

        // Second pulse while busy must be dropped.
        send(32'h3E00_0000);
        repeat (5) @(negedge clk);
        chk("busy_ready_low", 32'(ready_out), 0);
        valid_in = 1'b1;
        fp_in    = 32'h7A00_0000;
        @(negedge clk);
        valid_in = 1'b0;
        drain();

        // Reset in the middle of a shift discards the conversion.
        send(32'h3E00_0000);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_ready", 32'(ready_out), 1);
        chk("midreset_valid", 32'(valid_out), 0);
        chk("midreset_data", data_out, 0);
        chk("midreset_status", 32'(status_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(32'h3E00_0000);
        drain();

        // Random words, weighted toward the in-range exponents.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] w;
            w = $urandom;
            if (n % 3 != 0) w[30:25] = 6'($urandom_range(31, 63));
            send(w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
